// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port between NUM_MASTERS masters,
// holds the grant for the bus cycle (and while locked), and times out stalled strobes.
module wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TAGSIZE     = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    // master side
    input  logic [NUM_MASTERS*32-1:0]      m_wb_adr_o,
    input  logic [NUM_MASTERS*32-1:0]      m_wb_dat_o,
    input  logic [NUM_MASTERS*4-1:0]       m_wb_sel_o,
    input  logic [NUM_MASTERS*TAGSIZE-1:0] m_wb_tga_o,
    input  logic [NUM_MASTERS*TAGSIZE-1:0] m_wb_tgd_o,
    input  logic [NUM_MASTERS*TAGSIZE-1:0] m_wb_tgc_o,
    input  logic [NUM_MASTERS-1:0]         m_wb_cyc_o,
    input  logic [NUM_MASTERS-1:0]         m_wb_stb_o,
    input  logic [NUM_MASTERS-1:0]         m_wb_we_o,
    input  logic [NUM_MASTERS-1:0]         m_wb_lock_o,
    output logic [31:0]                    m_wb_dat_i,
    output logic [TAGSIZE-1:0]             m_wb_tgd_i,
    output logic [NUM_MASTERS-1:0]         m_wb_ack_i,
    output logic [NUM_MASTERS-1:0]         m_wb_err_i,
    output logic [NUM_MASTERS-1:0]         m_wb_rty_i,
    output logic [NUM_MASTERS-1:0]         m_wb_gnt_i,
    // slave side
    output logic [31:0]                    s_wb_adr_i,
    output logic [31:0]                    s_wb_dat_i,
    output logic [3:0]                     s_wb_sel_i,
    output logic [TAGSIZE-1:0]             s_wb_tga_i,
    output logic [TAGSIZE-1:0]             s_wb_tgd_i,
    output logic [TAGSIZE-1:0]             s_wb_tgc_i,
    output logic                           s_wb_cyc_i,
    output logic                           s_wb_stb_i,
    output logic                           s_wb_we_i,
    input  logic [31:0]                    s_wb_dat_o,
    input  logic [TAGSIZE-1:0]             s_wb_tgd_o,
    input  logic                           s_wb_ack_o,
    input  logic                           s_wb_err_o,
    input  logic                           s_wb_rty_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_next;
    logic [IDX_W-1:0]       owner, owner_next;
    logic [IDX_W-1:0]       prio, prio_next;
    logic [IDX_W-1:0]       pick;
    logic [WD_W-1:0]        wdog, wdog_next;
    logic [NUM_MASTERS-1:0] owner_hot;

    logic busy, any_req, release_bus, slave_resp, timeout_hit;
    logic own_cyc, own_stb, own_we, own_lock;
    logic [31:0]        sel_adr, sel_dat;
    logic [3:0]         sel_sel;
    logic [TAGSIZE-1:0] sel_tga, sel_tgd, sel_tgc;

    assign busy       = (state == BUSY);
    assign any_req    = |m_wb_cyc_o;
    assign slave_resp = s_wb_ack_o | s_wb_err_o | s_wb_rty_o;
    assign owner_hot  = NUM_MASTERS'(1) << owner;

    // Read data path is a plain broadcast; only the handshakes are steered.
    assign m_wb_dat_i = s_wb_dat_o;
    assign m_wb_tgd_i = s_wb_tgd_o;

    // Request mux: every master field selected by the current owner.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_adr  = '0;
        sel_dat  = '0;
        sel_sel  = '0;
        sel_tga  = '0;
        sel_tgd  = '0;
        sel_tgc  = '0;
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_adr  = m_wb_adr_o[i*32 +: 32];
                sel_dat  = m_wb_dat_o[i*32 +: 32];
                sel_sel  = m_wb_sel_o[i*4 +: 4];
                sel_tga  = m_wb_tga_o[i*TAGSIZE +: TAGSIZE];
                sel_tgd  = m_wb_tgd_o[i*TAGSIZE +: TAGSIZE];
                sel_tgc  = m_wb_tgc_o[i*TAGSIZE +: TAGSIZE];
                own_cyc  = m_wb_cyc_o[i];
                own_stb  = m_wb_stb_o[i];
                own_we   = m_wb_we_o[i];
                own_lock = m_wb_lock_o[i];
            end
        end
    end

    // Round-robin pick: scan downward so the requester closest to prio wins last.
    always_comb begin
        logic [IDX_W:0] idx;
        idx  = '0;
        pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = {1'b0, prio} + (IDX_W + 1)'(i);
            if (idx >= (IDX_W + 1)'(NUM_MASTERS))
                idx = idx - (IDX_W + 1)'(NUM_MASTERS);
            if (m_wb_cyc_o[idx[IDX_W-1:0]])
                pick = idx[IDX_W-1:0];
        end
    end

    assign release_bus = !own_cyc && !own_lock;
    assign timeout_hit = (TIMEOUT > 0) && busy && own_stb && !slave_resp
                         && (wdog == WD_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            prio  <= '0;
            wdog  <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            prio  <= prio_next;
            wdog  <= wdog_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        owner_next = owner;
        prio_next  = prio;
        wdog_next  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                    owner_next = pick;
                end
            end
            BUSY: begin
                if (release_bus) begin
                    state_next = IDLE;
                    prio_next  = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
                end
                if ((TIMEOUT > 0) && own_stb && !slave_resp && !timeout_hit)
                    wdog_next = wdog + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_wb_gnt_i = '0;
        m_wb_ack_i = '0;
        m_wb_err_i = '0;
        m_wb_rty_i = '0;
        s_wb_cyc_i = 1'b0;
        s_wb_stb_i = 1'b0;
        s_wb_we_i  = 1'b0;
        s_wb_adr_i = sel_adr;
        s_wb_dat_i = sel_dat;
        s_wb_sel_i = sel_sel;
        s_wb_tga_i = sel_tga;
        s_wb_tgd_i = sel_tgd;
        s_wb_tgc_i = sel_tgc;
        if (busy) begin
            m_wb_gnt_i = owner_hot;
            m_wb_ack_i = s_wb_ack_o ? owner_hot : '0;
            m_wb_err_i = (s_wb_err_o || timeout_hit) ? owner_hot : '0;
            m_wb_rty_i = s_wb_rty_o ? owner_hot : '0;
            s_wb_cyc_i = own_cyc;
            s_wb_stb_i = own_stb && !timeout_hit;
            s_wb_we_i  = own_we;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter (3 masters, TIMEOUT=4): stimulus queues expected
// output snapshots with cycle stamps; a monitor compares every change of the outputs.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int TS = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N*32-1:0] m_wb_adr_o, m_wb_dat_o;
    logic [N*4-1:0]  m_wb_sel_o;
    logic [N*TS-1:0] m_wb_tga_o, m_wb_tgd_o, m_wb_tgc_o;
    logic [N-1:0]    m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_lock_o;
    logic [31:0]     m_wb_dat_i;
    logic [TS-1:0]   m_wb_tgd_i;
    logic [N-1:0]    m_wb_ack_i, m_wb_err_i, m_wb_rty_i, m_wb_gnt_i;
    logic [31:0]     s_wb_adr_i, s_wb_dat_i;
    logic [3:0]      s_wb_sel_i;
    logic [TS-1:0]   s_wb_tga_i, s_wb_tgd_i, s_wb_tgc_i;
    logic            s_wb_cyc_i, s_wb_stb_i, s_wb_we_i;
    logic [31:0]     s_wb_dat_o;
    logic [TS-1:0]   s_wb_tgd_o;
    logic            s_wb_ack_o, s_wb_err_o, s_wb_rty_o;

    wb_arbiter #(.NUM_MASTERS(N), .TAGSIZE(TS), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_sel_o(m_wb_sel_o),
        .m_wb_tga_o(m_wb_tga_o), .m_wb_tgd_o(m_wb_tgd_o), .m_wb_tgc_o(m_wb_tgc_o),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_lock_o(m_wb_lock_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_tgd_i(m_wb_tgd_i),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .m_wb_rty_i(m_wb_rty_i),
        .m_wb_gnt_i(m_wb_gnt_i),
        .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_sel_i(s_wb_sel_i),
        .s_wb_tga_i(s_wb_tga_i), .s_wb_tgd_i(s_wb_tgd_i), .s_wb_tgc_i(s_wb_tgc_i),
        .s_wb_cyc_i(s_wb_cyc_i), .s_wb_stb_i(s_wb_stb_i), .s_wb_we_i(s_wb_we_i),
        .s_wb_dat_o(s_wb_dat_o), .s_wb_tgd_o(s_wb_tgd_o),
        .s_wb_ack_o(s_wb_ack_o), .s_wb_err_o(s_wb_err_o), .s_wb_rty_o(s_wb_rty_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] ack;
        logic [N-1:0] err;
        logic [N-1:0] rty;
        logic         scyc;
        logic         sstb;
        logic [31:0]  adr;   // slave address, only meaningful while strobing
        logic [31:0]  dat;   // read data, only meaningful while some ack is up
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_no = 0;
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc_no++;
    end

    task automatic check(input exp_t e, input snap_t got);
        checks++;
        if (e.cyc == cyc_no && got === e.s)
            passes++;
        else
            $display("FAIL %s: cycle %0d got %h, required cycle %0d %h",
                     e.name, cyc_no, got, e.cyc, e.s);
    endtask

    // Monitor: every time the observable outputs change, pop and compare one expectation.
    initial begin
        snap_t prev, cur;
        bit    have_prev;
        exp_t  e;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur.gnt  = m_wb_gnt_i;
                cur.ack  = m_wb_ack_i;
                cur.err  = m_wb_err_i;
                cur.rty  = m_wb_rty_i;
                cur.scyc = s_wb_cyc_i;
                cur.sstb = s_wb_stb_i;
                cur.adr  = s_wb_stb_i ? s_wb_adr_i : 32'h0;
                cur.dat  = (|m_wb_ack_i) ? m_wb_dat_i : 32'h0;
                if (!have_prev || cur !== prev) begin
                    have_prev = 1'b1;
                    prev = cur;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_event: cycle %0d got %h, required no change",
                                 cyc_no, cur);
                    end else begin
                        e = exp_q.pop_front();
                        check(e, cur);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string name, input int dc, input logic [N-1:0] g,
                             input logic [N-1:0] a, input logic [N-1:0] er,
                             input logic sc, input logic ss,
                             input logic [31:0] ad, input logic [31:0] dt);
        exp_t x;
        x.cyc    = cyc_no + dc;
        x.name   = name;
        x.s.gnt  = g;
        x.s.ack  = a;
        x.s.err  = er;
        x.s.rty  = '0;
        x.s.scyc = sc;
        x.s.sstb = ss;
        x.s.adr  = ad;
        x.s.dat  = dt;
        exp_q.push_back(x);
    endtask

    // Called in the first granted cycle of master m: zero-wait transfer, drop cyc,
    // then one idle cycle. 'rereq' re-raises m's cyc in the idle cycle, 'raise'
    // raises other masters' cyc in the drop cycle.
    task automatic grant_xfer(input string name, input int m, input logic [31:0] a,
                              input logic [31:0] d, input bit rereq, input logic [N-1:0] raise);
        logic [N-1:0] g;
        g = 3'b001 << m;
        expect_at({name, "_ack"},  0, g, g, '0, 1'b1, 1'b1, a, d);
        expect_at({name, "_drop"}, 1, g, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_at({name, "_idle"}, 2, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_wb_stb_o[m] = 1'b1;
        m_wb_adr_o[m*32 +: 32] = a;
        s_wb_ack_o = 1'b1;
        s_wb_dat_o = d;
        step();
        m_wb_cyc_o[m] = 1'b0;
        m_wb_stb_o[m] = 1'b0;
        m_wb_cyc_o = m_wb_cyc_o | raise;
        s_wb_ack_o = 1'b0;
        step();
        if (rereq) m_wb_cyc_o[m] = 1'b1;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        m_wb_adr_o = '0; m_wb_dat_o = '0; m_wb_sel_o = '0;
        m_wb_tga_o = '0; m_wb_tgd_o = '0; m_wb_tgc_o = '0;
        m_wb_cyc_o = '0; m_wb_stb_o = '0; m_wb_we_o = '0; m_wb_lock_o = '0;
        s_wb_dat_o = '0; s_wb_tgd_o = '0;
        s_wb_ack_o = 1'b0; s_wb_err_o = 1'b0; s_wb_rty_o = 1'b0;
        step();
        step();
        rst = 1'b0;
        expect_at("reset", 0, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        mon_en = 1'b1;
        step();

        // Contention: grants 0,1,2,0 with an idle cycle between each
        m_wb_cyc_o = 3'b111;
        step();
        grant_xfer("rr_m0", 0, 32'h0000_0100, 32'h1111_0000, 1'b1, '0);
        step();
        grant_xfer("rr_m1", 1, 32'h0000_0200, 32'h2222_0000, 1'b0, '0);
        step();
        grant_xfer("rr_m2", 2, 32'h0000_0300, 32'h3333_0000, 1'b0, '0);
        step();
        grant_xfer("rr_m0b", 0, 32'h0000_0400, 32'h4444_0000, 1'b0, '0);
        step();

        // Single request from master1, slave answers one cycle after the grant
        expect_at("single_gnt", 1, 3'b010, '0, '0, 1'b1, 1'b1, 32'h0000_1000, 32'h0);
        m_wb_cyc_o[1] = 1'b1;
        m_wb_stb_o[1] = 1'b1;
        m_wb_we_o[1]  = 1'b0;
        m_wb_adr_o[32 +: 32] = 32'h0000_1000;
        step();
        step();
        grant_xfer("single", 1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, '0);
        step();

        // Lock: master0 keeps the bus across a 2-cycle cyc gap; master1 waits
        m_wb_cyc_o[0]  = 1'b1;
        m_wb_lock_o[0] = 1'b1;
        m_wb_cyc_o[1]  = 1'b1;
        step();
        expect_at("lock_x1",   0, 3'b001, 3'b001, '0, 1'b1, 1'b1, 32'h0000_5000, 32'h5555_0001);
        expect_at("lock_gap",  1, 3'b001, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_at("lock_x2",   3, 3'b001, 3'b001, '0, 1'b1, 1'b1, 32'h0000_5004, 32'h5555_0002);
        expect_at("lock_drop", 4, 3'b001, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_at("lock_idle", 5, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_wb_stb_o[0] = 1'b1;
        m_wb_adr_o[0 +: 32] = 32'h0000_5000;
        s_wb_ack_o = 1'b1;
        s_wb_dat_o = 32'h5555_0001;
        step();
        m_wb_cyc_o[0] = 1'b0;
        m_wb_stb_o[0] = 1'b0;
        s_wb_ack_o = 1'b0;
        step();
        step();
        m_wb_cyc_o[0] = 1'b1;
        m_wb_stb_o[0] = 1'b1;
        m_wb_adr_o[0 +: 32] = 32'h0000_5004;
        s_wb_ack_o = 1'b1;
        s_wb_dat_o = 32'h5555_0002;
        step();
        m_wb_cyc_o[0]  = 1'b0;
        m_wb_stb_o[0]  = 1'b0;
        m_wb_lock_o[0] = 1'b0;
        s_wb_ack_o = 1'b0;
        step();
        step();
        grant_xfer("lock_m1", 1, 32'h0000_6000, 32'h6666_0000, 1'b0, '0);
        step();

        // Release/request race: master1 raises cyc as owner0 drops it
        m_wb_cyc_o[0] = 1'b1;
        step();
        grant_xfer("race_m0", 0, 32'h0000_7000, 32'h7777_0000, 1'b0, 3'b010);
        step();
        grant_xfer("race_m1", 1, 32'h0000_7100, 32'h7777_1111, 1'b0, '0);
        step();

        // Watchdog: error on the 5th unanswered strobe cycle, then ack beats the timeout
        m_wb_cyc_o[0] = 1'b1;
        step();
        expect_at("wd_strobe",  0, 3'b001, '0, '0, 1'b1, 1'b1, 32'h0000_2000, 32'h0);
        expect_at("wd_err",     4, 3'b001, '0, 3'b001, 1'b1, 1'b0, 32'h0, 32'h0);
        expect_at("wd_restrb",  5, 3'b001, '0, '0, 1'b1, 1'b1, 32'h0000_2000, 32'h0);
        m_wb_stb_o[0] = 1'b1;
        m_wb_adr_o[0 +: 32] = 32'h0000_2000;
        repeat (9) step();
        grant_xfer("wd_ack", 0, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, '0);
        step();

        // Reset while master2 owns the bus; arbitration restarts from master0
        m_wb_cyc_o[2] = 1'b1;
        step();
        expect_at("rst_own2",  0, 3'b100, '0, '0, 1'b1, 1'b0, 32'h0, 32'h0);
        expect_at("rst_idle",  1, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_at("rst_scan0", 2, 3'b001, '0, '0, 1'b1, 1'b0, 32'h0, 32'h0);
        expect_at("rst_drop",  3, 3'b001, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_at("rst_end",   4, '0, '0, '0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_wb_cyc_o[0] = 1'b1;
        step();
        m_wb_cyc_o[2] = 1'b0;
        step();
        m_wb_cyc_o[0] = 1'b0;
        repeat (4) step();

        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s: never observed, required at cycle %0d %h", e.name, e.cyc, e.s);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter that shares one Wishbone slave port between NUM_MASTERS master buses of the wb_master_bus_t / wb_slave_bus_t signal set. It sits between the cores/DMA engines and the interconnect slave side, and drives wb_gnt_i back to each master. A grant is held for the whole bus cycle, and across cycles while wb_lock_o is asserted. A built-in watchdog terminates stalled strobes with an error.

Parameters:
NUM_MASTERS, 2, number of master ports; legal range 2..8.
TAGSIZE, 2, width of all tag signals; matches the bus interface parameter.
TIMEOUT, 255, strobe cycles without slave response before the watchdog error fires; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_wb_adr_o  in  NUM_MASTERS*32  master addresses; slice i belongs to master i
m_wb_dat_o  in  NUM_MASTERS*32  master write data
m_wb_sel_o  in  NUM_MASTERS*4  master byte selects
m_wb_tga_o / m_wb_tgd_o / m_wb_tgc_o  in  NUM_MASTERS*TAGSIZE each  master address, data and cycle tags
m_wb_cyc_o / m_wb_stb_o / m_wb_we_o / m_wb_lock_o  in  NUM_MASTERS each  master cycle, strobe, write-enable and lock
m_wb_dat_i  out  32  read data, broadcast to all masters
m_wb_tgd_i  out  TAGSIZE  read data tag, broadcast to all masters
m_wb_ack_i / m_wb_err_i / m_wb_rty_i / m_wb_gnt_i  out  NUM_MASTERS each  per-master ack, error, retry and grant
s_wb_adr_i / s_wb_dat_i  out  32 each  to slave: address and write data
s_wb_sel_i  out  4  to slave: byte selects
s_wb_tga_i / s_wb_tgd_i / s_wb_tgc_i  out  TAGSIZE each  to slave: tags
s_wb_cyc_i / s_wb_stb_i / s_wb_we_i  out  1 each  to slave: cycle, strobe, write-enable
s_wb_dat_o  in  32  slave read data
s_wb_tgd_o  in  TAGSIZE  slave read data tag
s_wb_ack_o / s_wb_err_o / s_wb_rty_o  in  1 each  slave ack, error, retry

Behaviour:
- FSM states: IDLE, BUSY. Registers: owner (index), prio (round-robin pointer), wdog (counter).
- Reset (rst=1 at a clk edge) sets state=IDLE, prio=0, owner=0, wdog=0. Reset mid-transaction aborts it; no ack or err is issued for the aborted transfer.
- In IDLE, every output is 0: all gnt/ack/err/rty and s_wb_cyc_i/stb_i. Data and address outputs are don't-care but must not be X.
- IDLE -> BUSY when any m_wb_cyc_o[i]=1:
  - owner = first requester scanning prio, prio+1, ... modulo NUM_MASTERS.
  - m_wb_gnt_i[owner] rises on the next cycle, so grant latency is 1 cycle from cyc.
- BUSY routing, combinational from owner:
  - All s_wb_* request signals are muxed from master[owner].
  - s_wb_cyc_i = m_wb_cyc_o[owner].
  - s_wb_ack_o, s_wb_err_o and s_wb_rty_o go to master[owner] only; all other masters see 0.
  - m_wb_gnt_i is one-hot on owner.
- Release condition: m_wb_cyc_o[owner]=0 and m_wb_lock_o[owner]=0.
  - On release: state=IDLE and prio=(owner+1) mod NUM_MASTERS.
  - Release always passes through one IDLE cycle, even if other requests are pending (1-cycle bus gap).
- Lock: with lock=1 the grant is kept while cyc is low. Other masters stay blocked until lock drops.
- Non-owner strobes are ignored. A master must not assert stb without its gnt.
- Watchdog, active only when TIMEOUT>0:
  - In BUSY with m_wb_stb_o[owner]=1 and no slave ack/err/rty, wdog increments; any slave response or stb=0 clears it.
  - When wdog==TIMEOUT: m_wb_err_i[owner]=1 for exactly one cycle, s_wb_stb_i is forced to 0 that cycle, and wdog clears.
  - A slave response arriving in the same cycle as the timeout wins: it is forwarded and no watchdog error is issued.
- wdog width is clog2(TIMEOUT+1), with no wrap past TIMEOUT.

Test Plan:
- Single request: master1 asserts cyc+stb, we=0, adr=0x1000 → gnt[1]=1 one cycle later; slave sees adr=0x1000; slave ack with dat=0xDEADBEEF → ack[1]=1, m_wb_dat_i=0xDEADBEEF, ack[0]=0.
- Contention, NUM_MASTERS=3: all three hold cyc continuously, each cycle one transfer → grant order 0,1,2,0, with one IDLE cycle between grants.
- Lock: master0 runs cycles with lock=1, dropping cyc for 2 cycles between them; master1 requests throughout → gnt[0] stays 1 and gnt[1]=0 until lock=0 and cyc=0.
- Watchdog, TIMEOUT=4: master0 strobes and the slave never responds → err[0]=1 on the 5th stb cycle, s_wb_stb_i=0 that cycle; with a slave ack in the same cycle → ack[0]=1 and err[0]=0.
- Reset mid-transaction: assert rst while BUSY with owner=2 → next cycle all gnt=0, s_wb_cyc_i=0; next arbitration starts scanning from master0.
- Release/request race: owner0 drops cyc in the same cycle master1 raises cyc → one IDLE cycle, then gnt[1]=1.
